// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: 3-bit FSM state
// encoding and the halt opcode fill value.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } fetch_state_e;

    // The halt opcode is the instruction word with every bit set, at any INSTR_W.
    localparam logic HALT_OPCODE_FILL = 1'b1;

    localparam int RETIRED_W = 16;

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter with enable and synchronous reset;
// wraps from all ones back to zero.
module retire_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count register: clear on reset, advance by one on each enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {WIDTH{1'b0}};
        end else if (en) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue/execute sequencer for a single-issue core.
// Optional feature macro HALT_INSTR_EN: an all-ones instruction parks the FSM in HALT.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    pc_q,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0]   mem_data,
    output logic                 en_pc,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 alu_done,
    output logic                 busy,
    output logic [RETIRED_W-1:0] retired
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic         exec_done_s;

    assign mem_addr = pc_q;

    // Completion strobe: only alu_done seen while in EXEC counts, and reset wins.
    assign exec_done_s = (state_r == ST_EXEC) && alu_done && !reset;

    assign en_pc       = exec_done_s;
    assign instr_valid = (state_r == ST_ISSUE);
    assign busy        = (state_r != ST_IDLE) && (state_r != ST_HALT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction register: latched once per instruction, held through ISSUE/EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= {INSTR_W{1'b0}};
        end else if (state_r == ST_CAPTURE) begin
            instr <= mem_data;
        end else begin
            instr <= instr;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef HALT_INSTR_EN
                if (mem_data == {INSTR_W{HALT_OPCODE_FILL}}) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
`else
                state_next_s = ST_ISSUE;
`endif
            end
            ST_ISSUE: begin
                // A coincident alu_done here is deliberately not carried into EXEC.
                if (instr_ready) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_EXEC: begin
                if (alu_done) begin
                    if (stop) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    retire_counter #(
        .WIDTH (RETIRED_W)
    ) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .en    (exec_done_s),
        .count (retired)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; covers the HALT_INSTR_EN
// build when that macro is defined, otherwise the default build.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  pc_q;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        en_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_done;
    logic        busy;
    logic [15:0] retired;

    int checks;
    int failures;
    logic [15:0] exp_retired;

    fetch_sequencer #(
        .ADDR_W  (8),
        .INSTR_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .pc_q        (pc_q),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .en_pc       (en_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_done    (alu_done),
        .busy        (busy),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; pc_q = 8'h00;
        mem_data = 16'h0000; instr_ready = 1'b0; alu_done = 1'b0;
        tick();
        tick();

        // Reset state and combinational address path
        pc_q = 8'h42;
        settle();
        check_value("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_en_pc", {31'd0, en_pc}, 32'd0);
        check_value("rst_retired", {16'd0, retired}, 32'd0);
        check_value("rst_instr", {16'd0, instr}, 32'd0);
        check_value("mem_addr", {24'd0, mem_addr}, 32'h42);
        pc_q = 8'hFF;
        settle();
        check_value("mem_addr_ff", {24'd0, mem_addr}, 32'hFF);

        // start in cycle 0 -> instr_valid in cycle 3
        reset = 1'b0; start = 1'b1; mem_data = 16'h1234;
        tick();
        start = 1'b0;
        settle();
        check_value("fetch_busy", {31'd0, busy}, 32'd1);
        check_value("fetch_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_value("capture_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_value("issue_valid", {31'd0, instr_valid}, 32'd1);
        check_value("issue_instr", {16'd0, instr}, 32'h1234);

        // Stall in ISSUE; alu_done here must be ignored
        mem_data = 16'h5555; alu_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_value("stall_instr", {16'd0, instr}, 32'h1234);
            check_value("stall_en_pc", {31'd0, en_pc}, 32'd0);
        end
        alu_done = 1'b0;

        // Handshake, alu_done in 4th EXEC cycle
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_value("exec_wait_en_pc", {31'd0, en_pc}, 32'd0);
            check_value("exec_wait_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        alu_done = 1'b1;
        settle();
        check_value("exec_en_pc", {31'd0, en_pc}, 32'd1);
        check_value("exec_retired_pre", {16'd0, retired}, 32'd0);
        mem_data = 16'hABCD;
        tick();
        alu_done = 1'b0;
        settle();
        check_value("retired_1", {16'd0, retired}, 32'd1);
        check_value("post_exec_en_pc", {31'd0, en_pc}, 32'd0);
        check_value("post_exec_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check_value("refetch_valid", {31'd0, instr_valid}, 32'd1);
        check_value("refetch_instr", {16'd0, instr}, 32'hABCD);

        // ready and alu_done together in ISSUE: EXEC needs a fresh alu_done
        instr_ready = 1'b1; alu_done = 1'b1;
        settle();
        check_value("same_cycle_en_pc", {31'd0, en_pc}, 32'd0);
        tick();
        instr_ready = 1'b0; alu_done = 1'b0;
        settle();
        check_value("fresh_en_pc", {31'd0, en_pc}, 32'd0);
        tick();
        check_value("fresh_busy", {31'd0, busy}, 32'd1);
        check_value("fresh_retired", {16'd0, retired}, 32'd1);
        alu_done = 1'b1;
        settle();
        check_value("fresh_done_en_pc", {31'd0, en_pc}, 32'd1);
        mem_data = 16'hFFFF;
        tick();
        alu_done = 1'b0;
        check_value("retired_2", {16'd0, retired}, 32'd2);
        tick();
        tick();

`ifdef HALT_INSTR_EN
        // All-ones instruction parks the sequencer
        check_value("halt_valid", {31'd0, instr_valid}, 32'd0);
        check_value("halt_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; alu_done = 1'b1;
        settle();
        check_value("halt_en_pc", {31'd0, en_pc}, 32'd0);
        tick();
        tick();
        check_value("halt_start_busy", {31'd0, busy}, 32'd0);
        check_value("halt_start_valid", {31'd0, instr_valid}, 32'd0);
        check_value("halt_retired", {16'd0, retired}, 32'd2);
        start = 1'b0; alu_done = 1'b0;
        exp_retired = 16'd0;
`else
        // All-ones issued normally; stop during ISSUE lets it complete
        check_value("ones_valid", {31'd0, instr_valid}, 32'd1);
        check_value("ones_instr", {16'd0, instr}, 32'hFFFF);
        stop = 1'b1;
        tick();
        check_value("stop_issue_valid", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_value("stop_exec_busy", {31'd0, busy}, 32'd1);
        tick();
        check_value("stop_exec_busy2", {31'd0, busy}, 32'd1);
        alu_done = 1'b1;
        settle();
        check_value("stop_en_pc", {31'd0, en_pc}, 32'd1);
        tick();
        alu_done = 1'b0;
        settle();
        check_value("stop_idle_busy", {31'd0, busy}, 32'd0);
        check_value("stop_retired", {16'd0, retired}, 32'd3);
        check_value("stop_idle_en_pc", {31'd0, en_pc}, 32'd0);
        stop = 1'b0;
        tick();
        check_value("stop_stays_idle", {31'd0, busy}, 32'd0);
        exp_retired = 16'd3;
`endif

        // Reset clears a HALT and the next sequence starts cleanly
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (exp_retired == 16'd0) begin
            check_value("reset_clear_retired", {16'd0, retired}, 32'd0);
        end else begin
            exp_retired = 16'd0;
            check_value("reset_clear_retired2", {16'd0, retired}, 32'd0);
        end
        start = 1'b1; mem_data = 16'h0F0F;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_value("seq2_valid", {31'd0, instr_valid}, 32'd1);
        check_value("seq2_instr", {16'd0, instr}, 32'h0F0F);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_value("seq2_exec_busy", {31'd0, busy}, 32'd1);

        // Reset in EXEC beats alu_done/start/stop in the same cycle
        reset = 1'b1; alu_done = 1'b1; start = 1'b1; stop = 1'b1; instr_ready = 1'b1;
        settle();
        check_value("rst_prio_en_pc", {31'd0, en_pc}, 32'd0);
        tick();
        reset = 1'b0; alu_done = 1'b0; start = 1'b0; stop = 1'b0; instr_ready = 1'b0;
        settle();
        check_value("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
        check_value("rst_exec_instr", {16'd0, instr}, 32'd0);
        check_value("rst_exec_busy", {31'd0, busy}, 32'd0);
        check_value("rst_exec_en_pc", {31'd0, en_pc}, 32'd0);
        check_value("rst_exec_retired", {16'd0, retired}, {16'd0, exp_retired});
        tick();
        check_value("rst_exec_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction word width.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin fetching from current PC; sampled only in IDLE.
REQ-006 stop  in  1  request halt at next instruction boundary; level-sensitive.
REQ-007 pc_q  in  ADDR_W  current PC register value.
REQ-008 mem_addr  out  ADDR_W  instruction memory address; SHALL equal pc_q combinationally.
REQ-009 mem_data  in  INSTR_W  registered memory output; valid one cycle after address is presented.
REQ-010 en_pc  out  1  one-cycle pulse loading the branch-logic next-PC into the PC register.
REQ-011 instr  out  INSTR_W  captured instruction register.
REQ-012 instr_valid  out  1  instr valid for the execute stage.
REQ-013 instr_ready  in  1  execute stage accepts instr.
REQ-014 alu_done  in  1  execute complete; last ALU result stable for branch evaluation.
REQ-015 busy  out  1  high in every state except IDLE and HALT.
REQ-016 retired  out  16  count of completed instructions.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, CAPTURE, ISSUE, EXEC, HALT.
REQ-018 IDLE->FETCH when start=1; otherwise stay.
REQ-019 FETCH->CAPTURE unconditionally (one-cycle memory read latency).
REQ-020 CAPTURE SHALL load instr<=mem_data and go to ISSUE.
REQ-021 ISSUE SHALL drive instr_valid=1 and hold instr stable until instr_ready=1, then go to EXEC.
REQ-022 EXEC SHALL wait for alu_done=1; alu_done outside EXEC SHALL be ignored.
REQ-023 On alu_done in EXEC: en_pc=1 that cycle, retired increments by 1 (wraps 0xFFFF->0), next state FETCH if stop=0, IDLE if stop=1.
REQ-024 Latency: start sampled in cycle N -> instr_valid first high in cycle N+3.
REQ-025 en_pc SHALL never be high outside the alu_done cycle in EXEC.
REQ-026 stop SHALL NOT abort an instruction in FETCH, CAPTURE, ISSUE or EXEC.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 PC wrap-around (255->0) SHALL be owned by PC/branch logic; the sequencer SHALL not alter pc_q.
REQ-029 instr_ready and alu_done high in the same ISSUE cycle SHALL only complete the handshake; EXEC then waits for a fresh alu_done.

Reset
REQ-030 reset SHALL force state IDLE, instr=0, instr_valid=0, en_pc=0, busy=0, retired=0, from any state including mid-instruction.
REQ-031 reset SHALL take priority over start, stop, instr_ready and alu_done in the same cycle.

Configuration
REQ-032 With HALT_INSTR_EN defined: an instruction equal to all ones captured in CAPTURE SHALL go to HALT instead of ISSUE, with no instr_valid, no en_pc, no retired increment; HALT exits only on reset.
REQ-033 Without HALT_INSTR_EN: all-ones SHALL be issued like any other instruction and HALT SHALL be unreachable.

Structure
REQ-034 FSM state encoding (3-bit) and HALT opcode constant SHALL live in shared package fetch_pkg.
REQ-035 Retired counter SHALL be a sub-module retire_counter (16-bit, enable, synchronous reset).

Verification
REQ-036 reset, start=1 at cycle 0, mem_data=16'h1234 -> instr_valid high at cycle 3 with instr=16'h1234.
REQ-037 instr_ready held 0 for 5 cycles in ISSUE -> instr and instr_valid stable; no en_pc.
REQ-038 handshake, alu_done at 4th EXEC cycle -> exactly one en_pc pulse, retired 0->1, next state FETCH.
REQ-039 stop=1 asserted during ISSUE -> instruction completes, en_pc pulses once, state IDLE, busy=0.
REQ-040 reset asserted in EXEC -> next cycle all outputs at reset values, retired=0.
REQ-041 HALT_INSTR_EN defined, mem_data=16'hFFFF -> HALT, instr_valid=0, en_pc=0, busy=0; start ignored.
